ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 104 ++++++++++
 tb/tb_ifetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage with IF/ID register, branch/jump redirect and halt detection.
// Optional IFETCH_FETCH_COUNT_EN adds a free-running count of fetched instructions.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'd36
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        halted,
  output logic        misalign_err
`ifdef IFETCH_FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc_next, if_instr_next, if_pc4_next;
  logic        if_valid_next, misalign_next;
  logic [31:0] seq_pc, br_target, jmp_target, target;
  logic        redirect;

  assign seq_pc     = pc + 32'd4;
  assign br_target  = if_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jmp_target = {if_pc4[31:28], jump_index, 2'b00};
  assign target     = jump ? jmp_target : br_target;
  // A redirect only means something when the ID stage holds a real instruction.
  assign redirect   = if_valid && (jump || branch_taken);
  assign halted     = (state == HALT);

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    if_instr_next = if_instr;
    if_pc4_next   = if_pc4;
    if_valid_next = if_valid;
    misalign_next = misalign_err;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect) begin
          if_instr_next = 32'd0;
          if_valid_next = 1'b0;
          if (target[1:0] != 2'b00) begin
            misalign_next = 1'b1;
            state_next    = HALT;
          end else begin
            pc_next = target;
            if (target >= PC_LIMIT) state_next = HALT;
          end
        end else if (!stall) begin
          if_instr_next = instr;
          if_pc4_next   = seq_pc;
          if_valid_next = 1'b1;
          // The last in-range instruction is still latched; pc parks on it.
          if (seq_pc >= PC_LIMIT) state_next = HALT;
          else                    pc_next    = seq_pc;
        end
      end
      HALT: begin
        if (!stall) if_valid_next = 1'b0;
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      if_instr     <= 32'd0;
      if_pc4       <= 32'd0;
      if_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      if_instr     <= if_instr_next;
      if_pc4       <= if_pc4_next;
      if_valid     <= if_valid_next;
      misalign_err <= misalign_next;
    end
  end

`ifdef IFETCH_FETCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) fetch_count <= 32'd0;
    else if (state == RUN && !redirect && !stall) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboarded bench for ifetch_unit: a behavioural fetch model predicts the
// architectural state after every edge; a monitor compares it to the DUT.
module tb_ifetch_unit;

  localparam logic [31:0] LIMIT = 32'd36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, branch_taken, jump;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] pc, instr, if_instr, if_pc4;
  logic        if_valid, halted, misalign_err;
  logic [31:0] mem [16];

  logic        rst2, stall2, branch_taken2, jump2;
  logic [15:0] branch_offset2;
  logic [25:0] jump_index2;
  logic [31:0] pc2, if_instr2, if_pc4_2;
  logic        if_valid2, halted2, misalign_err2;

`ifdef IFETCH_FETCH_COUNT_EN
  logic [31:0] fetch_count, fetch_count2;
`endif

  assign instr = mem[pc[5:2]];

  ifetch_unit #(.RESET_PC(32'h0), .PC_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .if_instr(if_instr),
    .if_pc4(if_pc4), .if_valid(if_valid), .halted(halted),
    .misalign_err(misalign_err)
`ifdef IFETCH_FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  // Second instance starts on an unaligned pc so a branch can produce a misaligned target.
  ifetch_unit #(.RESET_PC(32'h2), .PC_LIMIT(LIMIT)) dut_mis (
    .clk(clk), .rst(rst2), .pc(pc2), .instr(32'h0000_1234), .stall(stall2),
    .branch_taken(branch_taken2), .branch_offset(branch_offset2),
    .jump(jump2), .jump_index(jump_index2), .if_instr(if_instr2),
    .if_pc4(if_pc4_2), .if_valid(if_valid2), .halted(halted2),
    .misalign_err(misalign_err2)
`ifdef IFETCH_FETCH_COUNT_EN
    , .fetch_count(fetch_count2)
`endif
  );

  typedef struct {
    logic [31:0] pc, instr, pc4, count;
    logic        valid, halt, mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [31:0] m_pc, m_pc4, m_instr, m_count;
  logic        m_valid, m_stop, m_mis, m_boot;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
  endtask

  // Drives one cycle of inputs, advances the model across the edge and queues its prediction.
  task automatic applyStimulus(input logic r, input logic s, input logic bt,
                               input logic [15:0] off, input logic j, input logic [25:0] ji);
    exp_t        e;
    logic [31:0] tgt;
    rst = r; stall = s; branch_taken = bt; branch_offset = off; jump = j; jump_index = ji;
    if (!r) begin
      m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_count = 32'h0;
      m_valid = 1'b0; m_stop = 1'b0; m_mis = 1'b0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_stop) begin
      if (!s) m_valid = 1'b0;
    end else if (m_valid && (j || bt)) begin
      if (j) tgt = (m_pc4 & 32'hF000_0000) | ({6'b0, ji} << 2);
      else   tgt = m_pc4 + 32'($signed(off) * 4);
      m_instr = 32'h0;
      m_valid = 1'b0;
      if ((tgt % 32'd4) != 32'd0) begin
        m_mis  = 1'b1;
        m_stop = 1'b1;
      end else begin
        m_pc = tgt;
        if (tgt >= LIMIT) m_stop = 1'b1;
      end
    end else if (!s) begin
      m_instr = mem[m_pc[5:2]];
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
      if (m_pc + 32'd4 >= LIMIT) m_stop = 1'b1;
      else                       m_pc   = m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.count = m_count;
    e.valid = m_valid; e.halt = m_stop; e.mis = m_mis;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc", pc, e.pc);
        checkOutput("if_instr", if_instr, e.instr);
        checkOutput("if_pc4", if_pc4, e.pc4);
        checkOutput("if_valid", {31'b0, if_valid}, {31'b0, e.valid});
        checkOutput("halted", {31'b0, halted}, {31'b0, e.halt});
        checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
`ifdef IFETCH_FETCH_COUNT_EN
        checkOutput("fetch_count", fetch_count, e.count);
`endif
      end
    end
  end

  initial begin : stimulus
    logic        r, s, bt, j;
    logic [15:0] off;
    logic [25:0] ji;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    rst2 = 1'b0; stall2 = 1'b0; branch_taken2 = 1'b0; jump2 = 1'b0;
    branch_offset2 = 16'h0; jump_index2 = 26'h0;

    // Reset, boot, fetch 0/4/8, then branch -2 words from if_pc4=12 with stall held.
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    applyStimulus(1, 0, 0, 16'h0, 0, 26'h0);
    repeat (3) applyStimulus(1, 0, 0, 16'h0, 0, 26'h0);
    applyStimulus(1, 1, 1, 16'hFFFE, 0, 26'h0);
    applyStimulus(1, 0, 0, 16'h0, 0, 26'h0);
    applyStimulus(1, 0, 1, 16'h0003, 1, 26'd6);
    applyStimulus(1, 0, 0, 16'h0, 0, 26'h0);
    repeat (3) applyStimulus(1, 1, 0, 16'h0, 0, 26'h0);
    repeat (6) applyStimulus(1, 0, 0, 16'h0, 0, 26'h0);
    applyStimulus(1, 0, 1, 16'hFFF0, 1, 26'd1);

    // Straight-line run to halt, then reset mid-run at pc=20.
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    repeat (12) applyStimulus(1, 0, 0, 16'h0, 0, 26'h0);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
    repeat (6) applyStimulus(1, 0, 0, 16'h0, 0, 26'h0);
    applyStimulus(0, 1, 1, 16'h1, 1, 26'h3);

    repeat (40) begin
      applyStimulus(0, 0, 0, 16'h0, 0, 26'h0);
      repeat (25) begin
        r   = ($urandom_range(0, 39) != 0);
        s   = ($urandom_range(0, 3) == 0);
        bt  = ($urandom_range(0, 6) == 0);
        j   = ($urandom_range(0, 12) == 0);
        off = 16'(int'($urandom_range(0, 20)) - 10);
        ji  = 26'($urandom_range(0, 12));
        applyStimulus(r, s, bt, off, j, ji);
      end
    end

    repeat (2) @(posedge clk);
    #4;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Unaligned start: pc=2 fetches, if_pc4=6, a zero-offset branch targets 6.
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mis_pc_after_fetch", pc2, 32'd6);
    checkOutput("mis_if_pc4", if_pc4_2, 32'd6);
    branch_taken2 = 1'b1;
    @(posedge clk); #1;
    branch_taken2 = 1'b0;
    checkOutput("mis_err_set", {31'b0, misalign_err2}, 32'd1);
    checkOutput("mis_halted", {31'b0, halted2}, 32'd1);
    checkOutput("mis_pc_held", pc2, 32'd6);
    checkOutput("mis_flushed", {31'b0, if_valid2}, 32'd0);
    checkOutput("mis_instr_nop", if_instr2, 32'd0);
    @(posedge clk); #1;
    checkOutput("mis_pc_still_held", pc2, 32'd6);
    checkOutput("mis_err_sticky", {31'b0, misalign_err2}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
